instruction_sequencer: RTL and testbench

Multicycle control FSM that sequences one instruction at a time through fetch, decode, execute, writeback and PC update for the 16-bit RISC core. It drives the program counter's update-style (PS) and branch-condition (BC) inputs and handshakes with instruction memory and the execute datapath. It also resolves branch taken/not-taken from the destination-register zero flag, so a not-taken branch increments the PC instead of holding it.

---
 rtl/instruction_sequencer_pkg.sv | 33 +++
 rtl/instruction_sequencer_opcode_decoder.sv | 24 ++
 rtl/instruction_sequencer.sv | 118 +++++++++++
 tb/tb_instruction_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Core-wide constants for the 16-bit RISC core: widths, opcodes and the
// PC update-style / branch-condition codes shared by sequencer and PC.
package instruction_sequencer_pkg;

    localparam int I_WIDTH   = 16;
    localparam int D_WIDTH   = 16;
    localparam int OP_WIDTH  = 4;
    localparam int CNT_WIDTH = 16;

    // PC update style
    typedef enum logic [1:0] {
        PS_HOLD      = 2'd0,
        PS_INCREMENT = 2'd1,
        PS_REL_JUMP  = 2'd2,
        PS_ABS_JUMP  = 2'd3
    } ps_e;

    // PC branch condition: the PC jumps when BC equals |D
    typedef enum logic {
        BC_ZERO  = 1'b0,
        BC_NZERO = 1'b1
    } bc_e;

    // Opcodes (IR[15:12]); 0x1..0xB is the ALU class
    localparam logic [OP_WIDTH-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_ALU_LO = 4'h1;
    localparam logic [OP_WIDTH-1:0] OP_ALU_HI = 4'hB;
    localparam logic [OP_WIDTH-1:0] OP_BRZ    = 4'hC;
    localparam logic [OP_WIDTH-1:0] OP_BRNZ   = 4'hD;
    localparam logic [OP_WIDTH-1:0] OP_JR     = 4'hE;
    localparam logic [OP_WIDTH-1:0] OP_HALT   = 4'hF;

endpackage

// File: rtl/instruction_sequencer_opcode_decoder.sv
// Combinational opcode classifier: one-hot instruction class from IR[15:12].
module opcode_decoder
    import instruction_sequencer_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    output logic                is_alu,
    output logic                is_nop,
    output logic                is_brz,
    output logic                is_brnz,
    output logic                is_jr,
    output logic                is_halt
);

    // Every 4-bit opcode lands in exactly one class
    always_comb begin
        is_alu  = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
        is_nop  = (op == OP_NOP);
        is_brz  = (op == OP_BRZ);
        is_brnz = (op == OP_BRNZ);
        is_jr   = (op == OP_JR);
        is_halt = (op == OP_HALT);
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multicycle control FSM: fetch, decode, execute, writeback and PC update,
// one instruction at a time. Resolves branches from the destination-register
// zero flag so not-taken branches simply increment the PC.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int iWidth   = I_WIDTH,
    parameter int opWidth  = OP_WIDTH,
    parameter int cntWidth = CNT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [iWidth-1:0]   imem_data,
    output logic [iWidth-1:0]   IR,
    output logic                exec_start,
    input  logic                exec_done,
    output logic                rf_we,
    input  logic                d_nz,
    output logic [1:0]          PS,
    output logic                BC,
    output logic                halted,
    output logic [cntWidth-1:0] instr_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_UPDATE_PC = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    logic [2:0] state;
    logic [2:0] next_state;

    // High from the second EXECUTE cycle on; lets exec_start pulse only once
    logic exec_busy;

    logic is_alu, is_nop, is_brz, is_brnz, is_jr, is_halt;

    opcode_decoder u_dec (
        .op      (IR[iWidth-1 -: opWidth]),
        .is_alu  (is_alu),
        .is_nop  (is_nop),
        .is_brz  (is_brz),
        .is_brnz (is_brnz),
        .is_jr   (is_jr),
        .is_halt (is_halt)
    );

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (run) next_state = S_FETCH;
            S_FETCH:     if (imem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (is_alu)       next_state = S_EXECUTE;
                else if (is_halt) next_state = S_HALT;
                else              next_state = S_UPDATE_PC;
            end
            S_EXECUTE:   if (exec_done) next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = S_UPDATE_PC;
            S_UPDATE_PC: next_state = S_FETCH;
            S_HALT:      if (run) next_state = S_UPDATE_PC;
            default:     next_state = S_IDLE;
        endcase
    end

    // State, instruction register, retire counter and execute-phase flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            IR          <= '0;
            instr_count <= '0;
            exec_busy   <= 1'b0;
        end else begin
            state     <= next_state;
            exec_busy <= (state == S_EXECUTE) && !exec_done;
            if (state == S_FETCH && imem_ready)
                IR <= imem_data;
            if (state == S_UPDATE_PC)
                instr_count <= instr_count + {{(cntWidth-1){1'b0}}, 1'b1};
        end
    end

    // Handshake/status outputs decode from state only
    always_comb begin
        imem_req   = (state == S_FETCH);
        exec_start = (state == S_EXECUTE) && !exec_busy;
        rf_we      = (state == S_WRITEBACK);
        halted     = (state == S_HALT);
    end

    // PC control: only UPDATE_PC moves the PC. A HALT opcode in IR here means
    // we are resuming, which steps past it like a NOP.
    always_comb begin
        PS = PS_HOLD;
        BC = BC_ZERO;
        if (state == S_UPDATE_PC) begin
            PS = PS_INCREMENT;
            if (is_brz && !d_nz) begin
                PS = PS_REL_JUMP;
                BC = BC_ZERO;
            end else if (is_brnz && d_nz) begin
                PS = PS_REL_JUMP;
                BC = BC_NZERO;
            end else if (is_jr && (d_nz == IR[iWidth-5])) begin
                PS = PS_ABS_JUMP;
                BC = IR[iWidth-5];
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: reset/start, ALU with waits,
// branches, jumps, halt/resume, counter wrap and reset mid-execute.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, imem_ready, exec_done, d_nz;
    logic [15:0] imem_data;
    logic        imem_req, exec_start, rf_we, BC, halted;
    logic [15:0] IR, instr_count;
    logic [1:0]  PS;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;

    instruction_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .IR          (IR),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .rf_we       (rf_we),
        .d_nz        (d_nz),
        .PS          (PS),
        .BC          (BC),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: a zero-wait fetch of a non-ALU instruction through UPDATE_PC
    task automatic do_short(input string tag, input logic [15:0] word, input logic dnz,
                            input logic [1:0] exp_ps, input logic exp_bc);
        chk({tag, ".req"}, imem_req, 1'b1);
        imem_ready = 1'b1;
        imem_data  = word;
        step();                                   // DECODE
        imem_ready = 1'b0;
        d_nz       = dnz;
        chk({tag, ".ir"}, IR, word);
        chk({tag, ".dec_ps"}, PS, 2'd0);
        step();                                   // UPDATE_PC
        chk({tag, ".ps"}, PS, exp_ps);
        chk({tag, ".bc"}, BC, exp_bc);
        chk({tag, ".nox"}, {exec_start, rf_we}, 2'b00);
        step();                                   // FETCH
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, ".cnt"}, instr_count, exp_cnt);
        chk({tag, ".back"}, {imem_req, PS}, 3'b100);
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; imem_ready = 1'b0; exec_done = 1'b0;
        d_nz = 1'b0; imem_data = 16'h0; exp_cnt = 16'h0;

        // Reset with run high: reset wins, all outputs quiet
        step();
        step();
        chk("rst.ctl", {imem_req, exec_start, rf_we, halted, PS, BC}, 7'b0);
        chk("rst.ir", IR, 16'h0);
        chk("rst.cnt", instr_count, 16'h0);

        reset = 1'b0;
        step();                                   // IDLE -> FETCH
        run = 1'b0;
        chk("start.req", imem_req, 1'b1);

        // ALU 0x1234: two fetch waits, exec_done on third EXECUTE cycle -> 9 cycles
        step();                                   // FETCH wait 1
        chk("alu.wait1", imem_req, 1'b1);
        step();                                   // FETCH wait 2 (3rd FETCH cycle)
        chk("alu.wait2", imem_req, 1'b1);
        imem_ready = 1'b1; imem_data = 16'h1234;
        step();                                   // DECODE
        imem_ready = 1'b0; imem_data = 16'hDEAD;
        chk("alu.ir", IR, 16'h1234);
        chk("alu.dec", {imem_req, exec_start}, 2'b00);
        step();                                   // EXECUTE 1
        chk("alu.start", exec_start, 1'b1);
        step();                                   // EXECUTE 2
        chk("alu.start2", exec_start, 1'b0);
        step();                                   // EXECUTE 3
        chk("alu.start3", {exec_start, rf_we}, 2'b00);
        exec_done = 1'b1;
        step();                                   // WRITEBACK
        exec_done = 1'b0;
        chk("alu.we", {rf_we, PS}, 3'b100);
        step();                                   // UPDATE_PC
        chk("alu.we_off", rf_we, 1'b0);
        chk("alu.ps", {PS, BC}, 3'b010);
        step();                                   // FETCH: 9th cycle done
        exp_cnt = 16'd1;
        chk("alu.cnt", instr_count, 16'd1);
        chk("alu.refetch", {imem_req, PS}, 3'b100);

        // Branches and jumps
        do_short("brz_t",  16'hC0F0, 1'b0, 2'd2, 1'b0);
        do_short("brnz_n", 16'hD0F0, 1'b0, 2'd1, 1'b0);
        do_short("brnz_t", 16'hD0F0, 1'b1, 2'd2, 1'b1);
        do_short("jr_t",   16'hE800, 1'b1, 2'd3, 1'b1);
        do_short("jr_n",   16'hE000, 1'b1, 2'd1, 1'b0);
        do_short("brz_n",  16'hC0F0, 1'b1, 2'd1, 1'b0);

        // HALT, idle 10 cycles, resume
        imem_ready = 1'b1; imem_data = 16'hF000;
        step();                                   // DECODE
        imem_ready = 1'b0;
        step();                                   // HALT
        for (int i = 0; i < 10; i++) begin
            chk("halt.hold", {halted, PS, imem_req}, 4'b1000);
            step();
        end
        chk("halt.still", halted, 1'b1);
        run = 1'b1;
        step();                                   // UPDATE_PC
        run = 1'b0;
        chk("halt.resume", {halted, PS, BC}, 4'b0010);
        step();                                   // FETCH
        exp_cnt = exp_cnt + 16'd1;
        chk("halt.cnt", instr_count, exp_cnt);
        chk("halt.fetch", imem_req, 1'b1);

        // Counter wrap: preset to 0xFFFF, retire one NOP
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        exp_cnt = 16'hFFFF;
        do_short("wrap", 16'h0000, 1'b0, 2'd1, 1'b0);
        chk("wrap.zero", instr_count, 16'h0000);

        // Reset during EXECUTE
        imem_ready = 1'b1; imem_data = 16'h2345;
        step();                                   // DECODE
        imem_ready = 1'b0;
        step();                                   // EXECUTE
        chk("mid.exec", exec_start, 1'b1);
        reset = 1'b1;
        step();                                   // IDLE
        reset = 1'b0;
        chk("mid.ir", IR, 16'h0);
        chk("mid.cnt", instr_count, 16'h0);
        chk("mid.ctl", {imem_req, exec_start, rf_we, halted, PS}, 6'b0);
        exec_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.idle", {imem_req, exec_start, rf_we, halted, PS}, 6'b0);
        end
        exec_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
